// File: rtl/gcd_arbiter.sv
// ---------------------------------------------------------------------------
// gcd_arbiter
//
// Purpose:
//   Round-robin scheduler that shares a single GCD engine among N requesters.
//   A granted requester's operand pair is latched onto the engine inputs and a
//   one-cycle go pulse is issued. The arbiter then waits for the engine's done,
//   captures the result and returns it to the requester with a one-cycle,
//   one-hot ack. Operand pairs containing a zero are answered directly without
//   using the engine. A cycle-count timeout aborts an operation whose done
//   never arrives and reports it through err.
//
// Parameters:
//   N           number of requesters (2..8)
//   W           operand/result width, matches the engine's in1/in2/out
//   TIMEOUT_CYC maximum counter value in WAIT before the operation is aborted
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous, active-low reset
//   req       per-requester request level (held until ack)
//   a_flat    operand A of requester i at [i*W +: W]
//   b_flat    operand B of requester i at [i*W +: W]
//   ack       one-hot, one-cycle completion pulse
//   result    GCD result, valid while ack != 0, held until the next response
//   err       timeout flag, valid while ack != 0, held until the next response
//   busy      high in every state except IDLE
//   grant_id  index of the requester currently being served
//   gcd_go    start pulse to the engine
//   gcd_in1   operand A to the engine
//   gcd_in2   operand B to the engine
//   gcd_out   result from the engine
//   gcd_done  completion from the engine (level or pulse)
// ---------------------------------------------------------------------------
module gcd_arbiter #(
    parameter int N           = 4,
    parameter int W           = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_flat,
    input  logic [N*W-1:0] b_flat,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   result,
    output logic           err,
    output logic           busy,
    output logic [2:0]     grant_id,
    output logic           gcd_go,
    output logic [W-1:0]   gcd_in1,
    output logic [W-1:0]   gcd_in2,
    input  logic [W-1:0]   gcd_out,
    input  logic           gcd_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [2:0]       ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [N-1:0]     ack_reg;
    logic [W-1:0]     result_reg;
    logic             err_reg;
    logic             busy_reg;
    logic [2:0]       grant_id_reg;
    logic             gcd_go_reg;
    logic [W-1:0]     gcd_in1_reg;
    logic [W-1:0]     gcd_in2_reg;

    // Per-requester operand views.
    logic [W-1:0] a_arr [N];
    logic [W-1:0] b_arr [N];

    // Requests rotated so that position 0 is the requester at the pointer.
    logic [2:0]   cand_id [N];
    logic [N-1:0] cand_req;

    logic         sel_found;
    logic [2:0]   sel_id;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    logic [3:0]   ptr_inc;
    logic [2:0]   ptr_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            logic [3:0] sum;

            assign a_arr[gi] = a_flat[gi*W +: W];
            assign b_arr[gi] = b_flat[gi*W +: W];

            // Candidate index (pointer + gi) mod N; pointer < N so one subtract suffices.
            assign sum         = {1'b0, ptr_reg} + 4'(gi);
            assign cand_id[gi] = (sum >= 4'(N)) ? 3'(sum - 4'(N)) : sum[2:0];
            assign cand_req[gi] = |(req & (N'(1) << cand_id[gi]));
        end
    endgenerate

    // First set request at or after the pointer: lowest rotated position wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                sel_found = 1'b1;
                sel_id    = cand_id[k];
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_id == 3'(k)) begin
                sel_a = a_arr[k];
                sel_b = b_arr[k];
            end
        end
    end

    assign ptr_inc  = {1'b0, grant_id_reg} + 4'd1;
    assign ptr_next = (ptr_inc >= 4'(N)) ? 3'd0 : ptr_inc[2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            ack_reg      <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            grant_id_reg <= '0;
            gcd_go_reg   <= 1'b0;
            gcd_in1_reg  <= '0;
            gcd_in2_reg  <= '0;
        end else begin
            // ack and go are single-cycle pulses; only the entering transition sets them.
            ack_reg    <= '0;
            gcd_go_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (sel_found) begin
                        grant_id_reg <= sel_id;
                        busy_reg     <= 1'b1;
                        if ((sel_a == '0) || (sel_b == '0)) begin
                            // gcd(0,x) = x and gcd(0,0) = 0: selecting the other
                            // operand covers every zero case without the engine.
                            result_reg <= (sel_a == '0) ? sel_b : sel_a;
                            err_reg    <= 1'b0;
                            ack_reg    <= N'(1) << sel_id;
                            state_reg  <= S_RESP;
                        end else begin
                            gcd_in1_reg <= sel_a;
                            gcd_in2_reg <= sel_b;
                            gcd_go_reg  <= 1'b1;
                            state_reg   <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end

                S_WAIT: begin
                    // A done seen in the first WAIT cycle may be left over from
                    // the previous operation (level-style done), so it is ignored.
                    if ((cnt_reg != '0) && gcd_done) begin
                        result_reg <= gcd_out;
                        err_reg    <= 1'b0;
                        ack_reg    <= N'(1) << grant_id_reg;
                        state_reg  <= S_RESP;
                    end else if (cnt_reg == CNT_W'(TIMEOUT_CYC)) begin
                        result_reg <= '0;
                        err_reg    <= 1'b1;
                        ack_reg    <= N'(1) << grant_id_reg;
                        state_reg  <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    ptr_reg   <= ptr_next;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_reg;
    assign result   = result_reg;
    assign err      = err_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_id_reg;
    assign gcd_go   = gcd_go_reg;
    assign gcd_in1  = gcd_in1_reg;
    assign gcd_in2  = gcd_in2_reg;

endmodule

// File: tb/tb_gcd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gcd_arbiter
//
// Directed bench for gcd_arbiter with a behavioural GCD engine model.
// Expected responses are queued when a request is driven and compared as the
// arbiter acknowledges them. The engine model can answer after a programmable
// delay, hold a stale done when go arrives, or hang forever.
// ---------------------------------------------------------------------------
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           err;
    logic           busy;
    logic [2:0]     grant_id;
    logic           gcd_go;
    logic [W-1:0]   gcd_in1;
    logic [W-1:0]   gcd_in2;
    logic [W-1:0]   gcd_out;
    logic           gcd_done;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_flat   (a_flat),
        .b_flat   (b_flat),
        .ack      (ack),
        .result   (result),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .gcd_go   (gcd_go),
        .gcd_in1  (gcd_in1),
        .gcd_in2  (gcd_in2),
        .gcd_out  (gcd_out),
        .gcd_done (gcd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int go_count = 0;
    int drive_cyc = 0;
    int last_ack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst && gcd_go) go_count <= go_count + 1;

    // ---------------- GCD engine model ----------------
    int          lat_cfg = 0;
    bit          stale_mode = 1'b0;
    bit          hang_mode = 1'b0;
    logic        m_pending;
    int          m_lat;
    logic [W-1:0] m_val;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a, b, t;
        a = x;
        b = y;
        for (int i = 0; i < 64 && b != 0; i++) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pending <= 1'b0;
            m_lat     <= 0;
            m_val     <= '0;
            gcd_done  <= 1'b0;
            gcd_out   <= '0;
        end else if (gcd_go && !hang_mode) begin
            m_pending <= 1'b1;
            m_lat     <= lat_cfg;
            m_val     <= gcd_ref(gcd_in1, gcd_in2);
            if (!stale_mode) gcd_done <= 1'b0;
        end else if (m_pending) begin
            if (m_lat == 0) begin
                gcd_done  <= 1'b1;
                gcd_out   <= m_val;
                m_pending <= 1'b0;
            end else begin
                m_lat    <= m_lat - 1;
                gcd_done <= 1'b0;
            end
        end else if (stale_mode) begin
            gcd_done <= 1'b1;
            gcd_out  <= 16'd99;
        end else begin
            gcd_done <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         e;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic e);
        exp_t x;
        a_flat[id*W +: W] = a;
        b_flat[id*W +: W] = b;
        req[id] = 1'b1;
        x.id  = id;
        x.res = res;
        x.e   = e;
        sb.push_back(x);
        drive_cyc = cyc;
        $display("t=%0t drive req[%0d] a=%0d b=%0d expect result=%0d err=%0d", $time, id, a, b, res, e);
    endtask

    // Wait for n acks within budget cycles, comparing each against the queue head.
    task automatic drain(input int n, input int budget);
        int got;
        exp_t x;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    x = sb.pop_front();
                    $display("t=%0t ack=%b result=%0d err=%0d", $time, ack, result, err);
                    check("ack_id", 32'(ack), 32'd1 << x.id);
                    check("result", 32'(result), 32'(x.res));
                    check("err", 32'(err), 32'(x.e));
                end
                req = req & ~ack;
                last_ack_cyc = cyc;
                got++;
            end
        end
        if (got != n) check("ack_count", 32'(got), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_gcd_go"}, 32'(gcd_go), 32'd0);
        check({tag, "_gcd_in1"}, 32'(gcd_in1), 32'd0);
        check({tag, "_gcd_in2"}, 32'(gcd_in2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int g0;

        rst    = 1'b0;
        req    = '0;
        a_flat = '0;
        b_flat = '0;
        repeat (2) step();
        check_all_zero("reset");
        rst = 1'b1;
        step();

        // Contention: all four at once, pointer 0 -> served 0,1,2,3.
        lat_cfg = 1;
        issue(0, 16'd12, 16'd8, 16'd4, 1'b0);
        issue(1, 16'd100, 16'd75, 16'd25, 1'b0);
        issue(2, 16'd81, 16'd27, 16'd27, 1'b0);
        issue(3, 16'd17, 16'd5, 16'd1, 1'b0);
        drain(4, 200);
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Re-request 0 and 2 after the pointer wraps back to 0.
        issue(2, 16'd49, 16'd14, 16'd7, 1'b0);
        sb.pop_back();
        issue(0, 16'd36, 16'd24, 16'd12, 1'b0);
        sb.push_back('{2, 16'd7, 1'b0});
        drain(2, 100);

        // Single op, minimum engine latency.
        step();
        lat_cfg = 0;
        g0 = go_count;
        issue(0, 16'd48, 16'd18, 16'd6, 1'b0);
        t0 = drive_cyc;
        step();
        check("issue_go", 32'(gcd_go), 32'd1);
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_grant", 32'(grant_id), 32'd0);
        check("issue_in1", 32'(gcd_in1), 32'd48);
        check("issue_in2", 32'(gcd_in2), 32'd18);
        drain(1, 50);
        check("normal_latency", 32'(last_ack_cyc - t0), 32'd4);
        check("single_go_count", 32'(go_count - g0), 32'd1);

        // Zero bypass: acked the cycle after grant, no engine start.
        g0 = go_count;
        step();
        issue(1, 16'd0, 16'd35, 16'd35, 1'b0);
        t0 = drive_cyc;
        drain(1, 20);
        check("bypass_a0_latency", 32'(last_ack_cyc - t0), 32'd1);
        step();
        issue(2, 16'd35, 16'd0, 16'd35, 1'b0);
        t0 = drive_cyc;
        drain(1, 20);
        check("bypass_b0_latency", 32'(last_ack_cyc - t0), 32'd1);
        step();
        issue(3, 16'd0, 16'd0, 16'd0, 1'b0);
        t0 = drive_cyc;
        drain(1, 20);
        check("bypass_00_latency", 32'(last_ack_cyc - t0), 32'd1);
        check("bypass_go_count", 32'(go_count - g0), 32'd0);

        // Stale done held when go arrives: must return the fresh result.
        step();
        stale_mode = 1'b1;
        lat_cfg = 2;
        repeat (2) step();
        issue(0, 16'd21, 16'd14, 16'd7, 1'b0);
        drain(1, 50);
        stale_mode = 1'b0;

        // Timeout: engine never answers.
        step();
        hang_mode = 1'b1;
        issue(1, 16'd30, 16'd12, 16'd0, 1'b1);
        t0 = drive_cyc;
        drain(1, 50);
        check("timeout_latency", 32'(last_ack_cyc - t0), 32'd11);
        hang_mode = 1'b0;
        lat_cfg = 1;
        step();
        issue(2, 16'd30, 16'd12, 16'd6, 1'b0);
        drain(1, 50);

        // Reset while waiting on a hung engine.
        step();
        hang_mode = 1'b1;
        a_flat[3*W +: W] = 16'd9;
        b_flat[3*W +: W] = 16'd6;
        req[3] = 1'b1;
        repeat (4) step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        $display("t=%0t reset asserted mid-operation", $time);
        step();
        hang_mode = 1'b0;
        rst = 1'b1;
        // req[3] is still high; pointer back at 0 must pick requester 1 first.
        issue(1, 16'd15, 16'd10, 16'd5, 1'b0);
        sb.push_back('{3, 16'd3, 1'b0});
        drain(2, 100);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
